// File: rtl/regfile_writeback.sv
// Register-file write-port driver: merges ALU results with a FIFO of LSU load results into one registered write per cycle.
// Optional macro WB_PENDING_QUERY_EN builds the per-entry pending-load compare behind query_pending_o.
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     reset,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_rd_i,
  input  logic [DATA_W-1:0]        alu_data_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [4:0]               lsu_rd_i,
  input  logic [DATA_W-1:0]        lsu_data_i,
  input  logic [4:0]               query_addr_i,
  output logic                     query_pending_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [4:0]               RDaddr_o,
  output logic [DATA_W-1:0]        RDdata_o,
  output logic                     RegWrite_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [4:0]        fifo_rd   [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];

  logic push;
  logic pop;
  logic alu_take;

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot early.
  assign lsu_ready_o  = (count < CW'(DEPTH));
  assign fifo_count_o = count;
  assign push         = lsu_valid_i && lsu_ready_o && (lsu_rd_i != 5'd0);
  assign alu_take     = alu_valid_i && (alu_rd_i != 5'd0);
  assign pop          = !alu_take && (count != '0);

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      RDaddr_o   <= 5'd0;
      RDdata_o   <= '0;
      RegWrite_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // ALU owns the slot when it has a real destination; otherwise the FIFO head drains.
      if (alu_take) begin
        RDaddr_o   <= alu_rd_i;
        RDdata_o   <= alu_data_i;
        RegWrite_o <= 1'b1;
      end else if (pop) begin
        RDaddr_o   <= fifo_rd[rd_ptr];
        RDdata_o   <= fifo_data[rd_ptr];
        RegWrite_o <= 1'b1;
      end else begin
        RegWrite_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= lsu_rd_i;
      fifo_data[wr_ptr] <= lsu_data_i;
    end
  end

`ifdef WB_PENDING_QUERY_EN
  logic [DEPTH-1:0] live;

  // Mark the slots between rd_ptr and rd_ptr+count-1 (mod DEPTH) as holding queued loads.
  always_comb begin
    live = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) live[rd_ptr + PW'(k)] = 1'b1;
    end
  end

  always_comb begin
    query_pending_o = RegWrite_o && (RDaddr_o == query_addr_i);
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (fifo_rd[i] == query_addr_i)) query_pending_o = 1'b1;
    end
    if (query_addr_i == 5'd0) query_pending_o = 1'b0;
  end
`else
  logic unused_query;
  assign unused_query    = ^query_addr_i;
  assign query_pending_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed steps plus random traffic against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              reset = 1'b1;
  logic              alu_valid_i = 1'b0;
  logic [4:0]        alu_rd_i = 5'd0;
  logic [DATA_W-1:0] alu_data_i = '0;
  logic              lsu_valid_i = 1'b0;
  logic              lsu_ready_o;
  logic [4:0]        lsu_rd_i = 5'd0;
  logic [DATA_W-1:0] lsu_data_i = '0;
  logic [4:0]        query_addr_i = 5'd0;
  logic              query_pending_o;
  logic [2:0]        fifo_count_o;
  logic [4:0]        RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic              RegWrite_o;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .query_addr_i(query_addr_i), .query_pending_o(query_pending_o),
    .fifo_count_o(fifo_count_o),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            q[$];
  logic              exp_we;
  logic [4:0]        exp_addr;
  logic [DATA_W-1:0] exp_data;
  int                checks = 0;
  int                failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_pending(input logic [4:0] qa);
    logic p;
    p = 1'b0;
`ifdef WB_PENDING_QUERY_EN
    if (qa != 5'd0) begin
      foreach (q[i]) if (q[i].rd == qa) p = 1'b1;
      if (exp_we && exp_addr == qa) p = 1'b1;
    end
`endif
    return p;
  endfunction

  task automatic modelReset();
    q.delete();
    exp_we   = 1'b0;
    exp_addr = 5'd0;
    exp_data = '0;
  endtask

  // One posedge of the reference behaviour: slot choice uses the queue as it was before this edge's push.
  task automatic modelStep();
    entry_t e;
    bit     ready;
    ready = (q.size() < DEPTH);
    if (alu_valid_i && alu_rd_i != 5'd0) begin
      exp_we = 1'b1; exp_addr = alu_rd_i; exp_data = alu_data_i;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_addr = e.rd; exp_data = e.data;
    end else begin
      exp_we = 1'b0;
    end
    if (lsu_valid_i && ready && lsu_rd_i != 5'd0) begin
      e.rd = lsu_rd_i; e.data = lsu_data_i;
      q.push_back(e);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".we"},      32'(RegWrite_o),      32'(exp_we));
    check({tag, ".addr"},    32'(RDaddr_o),        32'(exp_addr));
    check({tag, ".data"},    RDdata_o,             exp_data);
    check({tag, ".count"},   32'(fifo_count_o),    32'(q.size()));
    check({tag, ".ready"},   32'(lsu_ready_o),     32'(q.size() < DEPTH));
    check({tag, ".pending"}, 32'(query_pending_o), 32'(exp_pending(query_addr_i)));
  endtask

  // Drive one cycle of inputs just after a negedge, advance the model at posedge, check at the next negedge.
  task automatic applyStimulus(input string tag, input logic av, input logic [4:0] ard,
                               input logic [31:0] adata, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ldata, input logic [4:0] qa);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = adata;
    lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ldata;
    query_addr_i = qa;
    #1;
    check({tag, ".qcomb"}, 32'(query_pending_o), 32'(exp_pending(qa)));
    @(posedge clk_i);
    modelStep();
    @(negedge clk_i);
    checkOutput(tag);
  endtask

  initial begin
    logic [4:0] order [5];
    order[0] = 5'd1; order[1] = 5'd2; order[2] = 5'd3; order[3] = 5'd7; order[4] = 5'd8;
    modelReset();
    repeat (2) @(negedge clk_i);
    checkOutput("reset");
    reset = 1'b0;

    // ALU-only write and return to idle
    applyStimulus("alu", 1, 5, 32'hDEADBEEF, 0, 0, 0, 5);
    check("alu.addr_const", 32'(RDaddr_o), 32'd5);
    check("alu.data_const", RDdata_o, 32'hDEADBEEF);
    applyStimulus("alu_idle", 0, 0, 0, 0, 0, 0, 0);
    check("alu_idle.we_const", 32'(RegWrite_o), 32'd0);

    // ALU priority over queued loads, loads retire in order afterwards
    for (int i = 0; i < 5; i++) begin
      applyStimulus("prio", i < 3, 5'(i + 1), 32'h100 + i, i < 2, 5'(7 + i), 32'h11 * (i + 1), 7);
      check("prio.order", 32'(RDaddr_o), 32'(order[i]));
    end
    applyStimulus("prio_idle", 0, 0, 0, 0, 0, 0, 8);

    // Fill to DEPTH under continuous ALU traffic, then back-pressure
    for (int i = 0; i < 4; i++)
      applyStimulus("fill", 1, 5'(10 + i), 32'hA0 + i, 1, 5'(20 + i), 32'hB0 + i, 20);
    check("full.count_const", 32'(fifo_count_o), 32'd4);
    check("full.ready_const", 32'(lsu_ready_o), 32'd0);
    for (int i = 0; i < 2; i++)
      applyStimulus("held", 1, 5'(14 + i), 32'hC0 + i, 1, 5'd24, 32'hB4, 24);
    check("held.count_const", 32'(fifo_count_o), 32'd4);
    applyStimulus("drain1", 0, 0, 0, 1, 5'd24, 32'hB4, 24);
    check("drain1.count_const", 32'(fifo_count_o), 32'd3);
    check("drain1.ready_const", 32'(lsu_ready_o), 32'd1);
    applyStimulus("accept5", 0, 0, 0, 1, 5'd24, 32'hB4, 24);
    check("accept5.count_const", 32'(fifo_count_o), 32'd3);
    repeat (4) applyStimulus("drain", 0, 0, 0, 0, 0, 0, 24);

    // x0 filtering on both paths
    applyStimulus("x0_q", 1, 4, 32'h44, 1, 12, 32'h1212, 12);
    applyStimulus("x0_alu", 1, 0, 32'hFFFF, 0, 0, 0, 12);
    check("x0_alu.addr_const", 32'(RDaddr_o), 32'd12);
    applyStimulus("x0_lsu", 0, 0, 0, 1, 0, 32'h5555, 0);
    check("x0_lsu.count_const", 32'(fifo_count_o), 32'd0);

    // Pending query for rd 9 through FIFO and output register
    applyStimulus("pend_q", 1, 1, 32'h1, 1, 9, 32'h99, 9);
    applyStimulus("pend_hold", 1, 2, 32'h2, 0, 0, 0, 9);
    applyStimulus("pend_out", 0, 0, 0, 0, 0, 0, 9);
    applyStimulus("pend_done", 0, 0, 0, 0, 0, 0, 9);
    applyStimulus("pend_zero", 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream with three loads queued
    for (int i = 0; i < 3; i++)
      applyStimulus("pre_rst", 1, 5'(3 + i), 32'h30 + i, 1, 5'(16 + i), 32'h60 + i, 16);
    #2 reset = 1'b1;
    #1 modelReset();
    checkOutput("rst_mid");
    @(negedge clk_i);
    reset = 1'b0;
    repeat (3) applyStimulus("post_rst", 0, 0, 0, 0, 0, 0, 16);

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus("rand", $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
